// File: rtl/sr_drive_ctrl_if.sv
// rtl/sr_drive_ctrl_if.sv - target handshake and SR flop-bank drive/readback bundle
interface sr_drive_ctrl_if #(parameter int N = 4);
    logic         tgt_valid;
    logic [N-1:0] tgt_data;
    logic         tgt_ready;
    logic [N-1:0] S;
    logic [N-1:0] R;
    logic [N-1:0] q_fb;
    logic         done;
    logic         err;
    logic [N-1:0] err_mask;

    modport master (
        output tgt_valid, tgt_data, q_fb,
        input  tgt_ready, S, R, done, err, err_mask
    );

    modport slave (
        input  tgt_valid, tgt_data, q_fb,
        output tgt_ready, S, R, done, err, err_mask
    );
endinterface

// File: rtl/sr_drive_ctrl.sv
// rtl/sr_drive_ctrl.sv - drives an SR flop bank to a target word and verifies the readback
module sr_drive_ctrl #(
    parameter int N    = 4,
    parameter int HOLD = 2
) (
    input  logic          clk,
    input  logic          rst,
    sr_drive_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    state_t       state;
    state_t       state_next;
    logic [3:0]   cnt;
    logic [N-1:0] tgt_q;
    logic [N-1:0] shadow;
    logic         shadow_vld;
    logic         done_q;
    logic         err_q;
    logic [N-1:0] err_mask_q;
    logic [N-1:0] mism;

    assign mism = bus.q_fb ^ tgt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.tgt_valid) state_next = DRIVE;
            DRIVE:   if (cnt == HOLD_LAST) state_next = CHECK;
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Only bits that differ from the last written word are excited, unless
    // the bank content is unknown since reset, in which case every bit is forced.
    always_comb begin
        bus.tgt_ready = (state == IDLE);
        bus.S         = '0;
        bus.R         = '0;
        if (state == DRIVE) begin
            if (shadow_vld) begin
                bus.S = tgt_q & ~shadow;
                bus.R = ~tgt_q & shadow;
            end else begin
                bus.S = tgt_q;
                bus.R = ~tgt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            tgt_q      <= '0;
            shadow     <= '0;
            shadow_vld <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_mask_q <= '0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_mask_q <= '0;
            case (state)
                IDLE: begin
                    if (bus.tgt_valid) begin
                        tgt_q <= bus.tgt_data;
                        cnt   <= '0;
                    end
                end
                DRIVE: begin
                    cnt <= (cnt == HOLD_LAST) ? 4'd0 : cnt + 4'd1;
                end
                CHECK: begin
                    done_q     <= 1'b1;
                    err_q      <= |mism;
                    err_mask_q <= mism;
                    shadow     <= tgt_q;
                    shadow_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_mask = err_mask_q;
endmodule

// File: tb/tb_sr_drive_ctrl.sv
// tb/tb_sr_drive_ctrl.sv - directed vector bench for sr_drive_ctrl with a modelled SR flop bank
module tb_sr_drive_ctrl;
    localparam int N    = 4;
    localparam int HOLD = 2;

    typedef struct {
        logic [3:0] tgt;
        logic [3:0] s;
        logic [3:0] r;
        logic [3:0] mask;
        logic       err;
        logic       stuck;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stuck = 1'b0;
    logic [3:0] q_bank = 4'b0000;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_hs = -100;
    vec_t vecs[5];

    sr_drive_ctrl_if #(.N(N)) bus ();

    sr_drive_ctrl #(.N(N), .HOLD(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Flop bank model: set/reset dominate, otherwise hold; bit0 optionally stuck high
    always @(posedge clk) q_bank <= (q_bank | bus.S) & ~bus.R;
    assign bus.q_fb = q_bank | {3'b000, stuck};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            last_hs <= -100;
        end else if (bus.tgt_valid && bus.tgt_ready) begin
            chk("handshake_spacing", 32'(cyc - last_hs >= HOLD + 2), 32'd1);
            last_hs <= cyc;
        end
    end

    always @(negedge clk) begin
        chk("s_and_r_zero", 32'(bus.S & bus.R), 32'd0);
    end

    // Entered at a negedge with the block expected ready; leaves in the done cycle
    task automatic do_update(input vec_t v);
        int w = 0;
        stuck = v.stuck;
        while (!bus.tgt_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before", 32'(bus.tgt_ready), 32'd1);
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = v.tgt;
        @(negedge clk);
        bus.tgt_valid = 1'b0;
        bus.tgt_data  = ~v.tgt;
        for (int i = 0; i < HOLD; i++) begin
            chk("drive_S", 32'(bus.S), 32'(v.s));
            chk("drive_R", 32'(bus.R), 32'(v.r));
            chk("drive_ready", 32'(bus.tgt_ready), 32'd0);
            chk("drive_done", 32'(bus.done), 32'd0);
            @(negedge clk);
        end
        chk("check_S", 32'(bus.S), 32'd0);
        chk("check_R", 32'(bus.R), 32'd0);
        chk("check_ready", 32'(bus.tgt_ready), 32'd0);
        chk("check_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        chk("done", 32'(bus.done), 32'd1);
        chk("err", 32'(bus.err), 32'(v.err));
        chk("err_mask", 32'(bus.err_mask), 32'(v.mask));
        chk("done_ready", 32'(bus.tgt_ready), 32'd1);
    endtask

    initial begin
        vec_t post;
        vecs[0] = '{tgt: 4'b1010, s: 4'b1010, r: 4'b0101, mask: 4'b0000, err: 1'b0, stuck: 1'b0};
        vecs[1] = '{tgt: 4'b0110, s: 4'b0100, r: 4'b1000, mask: 4'b0000, err: 1'b0, stuck: 1'b0};
        vecs[2] = '{tgt: 4'b0000, s: 4'b0000, r: 4'b0110, mask: 4'b0001, err: 1'b1, stuck: 1'b1};
        vecs[3] = '{tgt: 4'b1111, s: 4'b1111, r: 4'b0000, mask: 4'b0000, err: 1'b0, stuck: 1'b0};
        vecs[4] = '{tgt: 4'b1111, s: 4'b0000, r: 4'b0000, mask: 4'b0000, err: 1'b0, stuck: 1'b0};
        post    = '{tgt: 4'b0110, s: 4'b0110, r: 4'b1001, mask: 4'b0000, err: 1'b0, stuck: 1'b0};

        bus.tgt_valid = 1'b0;
        bus.tgt_data  = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(bus.tgt_ready), 32'd1);
        chk("rst_S", 32'(bus.S), 32'd0);
        chk("rst_R", 32'(bus.R), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_mask", 32'(bus.err_mask), 32'd0);

        for (int k = 0; k < 5; k++) do_update(vecs[k]);

        // Reset in the second DRIVE cycle aborts the update without a done pulse
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 4'b0011;
        @(negedge clk);
        bus.tgt_valid = 1'b0;
        chk("abort_S", 32'(bus.S), 32'd0);
        chk("abort_R", 32'(bus.R), 32'b1100);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_rst_S", 32'(bus.S), 32'd0);
        chk("abort_rst_R", 32'(bus.R), 32'd0);
        chk("abort_rst_ready", 32'(bus.tgt_ready), 32'd1);
        chk("abort_rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        chk("abort_no_done", 32'(bus.done), 32'd0);
        chk("abort_idle_ready", 32'(bus.tgt_ready), 32'd1);

        do_update(post);
        @(negedge clk);
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("err_one_cycle", 32'(bus.err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sr_drive_ctrl.md
SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

Interface
REQ-001 Parameter N, default 4: number of downstream SR flip-flops driven; legal range 1..16.
REQ-002 Parameter HOLD, default 2: cycles S/R held per update; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 tgt_valid  input  1  target word offered.
REQ-006 tgt_data  input  N  desired Q value, one bit per flop.
REQ-007 tgt_ready  output  1  block can accept a target.
REQ-008 S  output  N  set drive to the flop bank.
REQ-009 R  output  N  reset drive to the flop bank.
REQ-010 q_fb  input  N  Q outputs fed back from the flop bank.
REQ-011 done  output  1  one-cycle pulse: an update has completed.
REQ-012 err  output  1  one-cycle pulse alongside done: readback mismatch.
REQ-013 err_mask  output  N  q_fb XOR target, valid while done=1; 0 otherwise.

Function
REQ-014 FSM states SHALL be IDLE, DRIVE and CHECK, with no other reachable state.
REQ-015 IDLE: tgt_ready=1, S=R=0; on tgt_valid=1 the block SHALL capture tgt_data into tgt_q and go to DRIVE; with tgt_valid=0 it stays in IDLE.
REQ-016 tgt_ready SHALL be 0 in DRIVE and CHECK, and tgt_data SHALL be ignored there.
REQ-017 Excitation with shadow_vld=1: per bit, S=tgt_q&~shadow, R=~tgt_q&shadow; unchanged bits get S=R=0 (hold).
REQ-018 Excitation with shadow_vld=0 (first update after reset): S=tgt_q, R=~tgt_q for every bit (forced full drive).
REQ-019 S&R SHALL be 0 for every bit in every cycle, so the invalid SR input combination never occurs.
REQ-020 DRIVE SHALL last exactly HOLD cycles with S/R constant, counted by a 4-bit counter, then go to CHECK.
REQ-021 CHECK lasts one cycle with S=R=0; the block SHALL sample q_fb, go to IDLE, and register done=1, err=|(q_fb^tgt_q), err_mask=q_fb^tgt_q.
REQ-022 On leaving CHECK: shadow SHALL be loaded with tgt_q and shadow_vld set to 1, even when err=1.
REQ-023 An all-hold update (S=R=0 for all bits in DRIVE) SHALL still take the full DRIVE and CHECK sequence.
REQ-024 Latency: a handshake in cycle t SHALL produce S/R in cycles t+1..t+HOLD, CHECK in t+HOLD+1, done and tgt_ready=1 in t+HOLD+2; throughput is one update per HOLD+2 cycles.
REQ-025 A tgt_valid held high in the cycle done pulses SHALL be accepted that same cycle, since tgt_ready=1 then.
REQ-026 done and err SHALL each be high for exactly one cycle per update.
REQ-027 X or Z on q_fb in CHECK SHALL not corrupt FSM state.

Reset
REQ-028 When rst=1 at a clock edge, outputs SHALL be set: tgt_ready=1 (state IDLE), S=0, R=0, done=0, err=0, err_mask=0.
REQ-029 rst=1 SHALL also clear shadow=0, shadow_vld=0, counter=0 and tgt_q=0.
REQ-030 rst SHALL take priority over every other input in any state; a reset mid-DRIVE ends the update at once, with S=R=0 and no done pulse.

Verification (N=4, HOLD=2, bench models the flop bank from S/R)
REQ-031 Reset, then target 4'b1010 -> S=1010 and R=0101 for 2 cycles; done 4 cycles after the handshake; err=0.
REQ-032 From 1010, target 4'b0110 -> S=0100 and R=1000 for 2 cycles, other bits hold; done pulses with err=0, err_mask=0.
REQ-033 Bench forces q_fb bit0 stuck at 1 and targets 0000 -> done=1, err=1, err_mask=0001; next target still accepted.
REQ-034 Back-to-back tgt_valid=1 with targets 1111, 1111 -> second update accepted in the first update's done cycle, with S=R=0000 throughout its DRIVE, and done pulses twice.
REQ-035 rst asserted in the second DRIVE cycle -> next cycle S=R=0, tgt_ready=1, no done; next target drives with S=tgt, R=~tgt.
REQ-036 Every test: assert S&R==0 on all cycles, and never more than one handshake per HOLD+2 cycles.
